lane_result_packer: RTL and testbench
=====================================

Name: lane_result_packer

Overview:
- Sits directly downstream of the SIMD lane.
- Absorbs the lane's 64-bit result vectors (8 x int8, valid-only, no backpressure).
- Packs PACK consecutive vectors into one wide beat and buffers beats in a small FIFO.
- Presents the beats on a valid/ready interface to the writeback path, which may stall.
- Detects and flags overflow, because the lane cannot be stalled.

Parameters:
- DATA_W, 64: width of one lane result vector (8 bytes).
- PACK, 2: lane vectors per output beat (1..4).
- DEPTH, 8: FIFO depth in beats (power of two, >= 2).
- OUT_W, DATA_W*PACK: output beat width (derived; do not override).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_data  in  DATA_W  lane result vector; byte b is at [b*8+7:b*8].
- i_data_v  in  1  i_data valid; no ready is returned.
- i_flush  in  1  close the current partial beat (end of tile).
- o_data  out  OUT_W  packed beat; slot k is at [k*DATA_W +: DATA_W].
- o_data_v  out  1  FIFO head valid.
- o_data_rdy  in  1  consumer accepts the head when o_data_v & o_data_rdy.
- o_keep  out  PACK  per-slot valid mask of the head beat.
- o_last  out  1  head beat was closed by a flush.
- o_count  out  $clog2(DEPTH)+1  beats currently stored.
- o_overflow  out  1  sticky: a beat was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, async): slot index = 0, pack register = 0, FIFO pointers = 0. All outputs read 0: o_data_v, o_data, o_keep, o_last, o_count, o_overflow.
- Packing:
  - Each cycle with i_data_v=1 writes i_data into slot[slot_idx].
  - slot_idx increments modulo PACK.
  - Slot 0 occupies the LSBs of the beat.
- Full beat:
  - Condition: i_data_v=1 and slot_idx=PACK-1.
  - At that edge the beat {i_data, held slots} is pushed with keep=all ones and last=i_flush.
  - slot_idx returns to 0 and the pack register clears to 0.
- Flush:
  - Data in the same cycle is taken first.
  - If slots are then partially filled, push the partial beat: unfilled slots = 0, keep = filled slots, last=1. slot_idx returns to 0.
  - If no slot is pending and no data arrives, flush is a no-op; no beat is pushed.
- FIFO:
  - First-word fall-through.
  - o_data_v = (count != 0).
  - o_data, o_keep and o_last reflect the head combinationally from storage.
  - Pop occurs on o_data_v & o_data_rdy.
- Latency: a beat pushed at edge N is visible with o_data_v=1 in the cycle after edge N (1 cycle from the final i_data_v).
- Simultaneous push and pop:
  - Allowed at any occupancy, including full: the pop frees the entry.
  - count is unchanged and the beat is accepted.
- Overflow:
  - Condition: push while count=DEPTH and no pop that cycle.
  - The beat is dropped and the FIFO is unchanged.
  - o_overflow is set the next cycle and held until reset.
  - Packing continues normally after an overflow.
- Pointers wrap modulo DEPTH. count is exact from 0 to DEPTH.
- Reset mid-operation discards the pending slots and all stored beats immediately.

Optional Feature:
- Macro: LANE_RESULT_PACKER_RELU_EN.
- Defined: each byte of i_data is treated as signed int8 and clamped to 0x00 if bit 7 = 1, before it is stored in a slot.
- Undefined: bytes pass through unmodified.
- The feature has no effect on timing or on any other port.

Decomposition:
- Package lane_pkg holds:
  - LANE_W=64, BYTE_W=8, BYTES_PER_LANE=8;
  - the beat struct typedef {data, keep, last};
  - a function computing the FIFO count width.
- Sub-module lane_beat_fifo: synchronous FWFT FIFO storing the beat struct, with count and full/empty.
- The top level holds the packer, flush logic, overflow flag and ReLU option.

Test Plan:
- PACK=2, rdy=1: drive 4 vectors A,B,C,D on consecutive cycles.
  - Expect beat {B,A} with keep=2'b11, last=0 one cycle after B.
  - Then beat {D,C}.
- Drive vector A, then i_flush alone.
  - Expect one beat {0,A}, keep=2'b01, last=1.
  - A further flush with nothing pending pushes no beat.
- Drive A, then B together with i_flush.
  - Expect a single beat {B,A}, keep=2'b11, last=1.
- Hold rdy=0 and push 9 full beats into DEPTH=8.
  - Expect count=8 and o_overflow=1.
  - Beat 9 absent: draining yields beats 1..8 in order.
- At count=8, push and pop in the same cycle.
  - Expect count to stay 8, no overflow, and the new beat delivered last.
- ReLU enabled: i_data=0x80_7F_FF_01_00_90_10_C0, PACK=1.
  - Expect o_data=0x00_7F_00_01_00_00_10_00.
  - With the macro undefined, o_data equals the input.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared constants and types for the lane result packer.
// Provides lane geometry, the default beat payload struct and the
// helper that sizes the FIFO occupancy counter.
package lane_pkg;

  localparam int unsigned LANE_W         = 64;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_LANE = LANE_W / BYTE_W;
  localparam int unsigned DEF_PACK       = 2;

  // Beat payload for the default packing factor; the top re-declares the
  // same layout sized for its own PACK.
  typedef struct packed {
    logic [LANE_W*DEF_PACK-1:0] data;
    logic [DEF_PACK-1:0]        keep;
    logic                       last;
  } lane_beat_t;

  // Counter must represent 0..depth inclusive.
  function automatic int unsigned fifo_count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lane_beat_fifo.sv
// Synchronous first-word-fall-through FIFO of beat structs.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, din    write request and payload
//   pop          read request (ignored when empty)
//   head         current head entry, zero when empty
//   count        stored entries (0..DEPTH)
//   full, empty  occupancy flags
// A push while full is accepted only if a pop frees the slot that cycle.
module lane_beat_fifo
  import lane_pkg::*;
#(
  parameter type         beat_t = lane_beat_t,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W = fifo_count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  beat_t            din,
  input  logic             pop,
  output beat_t            head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  beat_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_c;
  logic             do_pop_c;

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_c  = pop & (count_q != '0);
    do_push_c = push & ((count_q != CNT_W'(DEPTH)) | do_pop_c);
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/lane_result_packer.sv
// Packs PACK consecutive SIMD lane result vectors into one wide beat and
// buffers the beats in a FWFT FIFO towards a stallable writeback path.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   i_data, i_data_v    lane result vector and valid (no backpressure)
//   i_flush             close the current partial beat
//   o_data, o_data_v    head beat and valid; o_data_rdy accepts it
//   o_keep, o_last      per-slot valid mask, beat closed by flush
//   o_count             beats stored
//   o_overflow          sticky: a beat was dropped on a full FIFO
// Build option LANE_RESULT_PACKER_RELU_EN: clamp negative int8 bytes to 0
// before they are stored.
module lane_result_packer
  import lane_pkg::*;
#(
  parameter int unsigned DATA_W = LANE_W,
  parameter int unsigned PACK   = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned OUT_W  = DATA_W * PACK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_data_v,
  input  logic                   i_flush,
  output logic [OUT_W-1:0]       o_data,
  output logic                   o_data_v,
  input  logic                   o_data_rdy,
  output logic [PACK-1:0]        o_keep,
  output logic                   o_last,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);

  localparam int unsigned SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned NBYTES = DATA_W / BYTE_W;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [PACK-1:0]  keep;
    logic             last;
  } beat_t;

  logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
  logic [OUT_W-1:0]  pack_q, pack_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] lane_vec_c;
  logic [OUT_W-1:0]  merged_c;
  logic [SLOT_W:0]   fill_c;
  logic              push_c;
  beat_t             push_beat_c;
  beat_t             head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              pop_c;

  // Optional ReLU on each signed byte of the incoming vector.
  always_comb begin
    lane_vec_c = i_data;
`ifdef LANE_RESULT_PACKER_RELU_EN
    for (int b = 0; b < NBYTES; b++) begin
      if (i_data[b*BYTE_W + BYTE_W - 1]) lane_vec_c[b*BYTE_W +: BYTE_W] = '0;
    end
`endif
  end

  assign pop_c = ~fifo_empty_c & o_data_rdy;

  // Packer: slot write, full-beat close, flush close, overflow flag.
  always_comb begin
    slot_idx_d  = slot_idx_q;
    pack_d      = pack_q;
    overflow_d  = overflow_q;
    push_c      = 1'b0;
    push_beat_c = '0;
    merged_c    = pack_q;

    for (int k = 0; k < PACK; k++) begin
      if (SLOT_W'(k) == slot_idx_q) merged_c[k*DATA_W +: DATA_W] = lane_vec_c;
    end

    // Slots occupied once this cycle's data (if any) is taken.
    fill_c = i_data_v ? (SLOT_W+1)'(slot_idx_q) + (SLOT_W+1)'(1)
                      : (SLOT_W+1)'(slot_idx_q);

    if (i_data_v && (slot_idx_q == SLOT_W'(PACK - 1))) begin
      push_c           = 1'b1;
      push_beat_c.data = merged_c;
      push_beat_c.keep = '1;
      push_beat_c.last = i_flush;
      pack_d           = '0;
      slot_idx_d       = '0;
    end else if (i_flush && (fill_c != '0)) begin
      push_c           = 1'b1;
      push_beat_c.data = i_data_v ? merged_c : pack_q;
      for (int k = 0; k < PACK; k++) begin
        push_beat_c.keep[k] = ((SLOT_W+1)'(k) < fill_c);
      end
      push_beat_c.last = 1'b1;
      pack_d           = '0;
      slot_idx_d       = '0;
    end else if (i_data_v) begin
      pack_d     = merged_c;
      slot_idx_d = slot_idx_q + SLOT_W'(1);
    end

    if (push_c && fifo_full_c && !pop_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_idx_q <= '0;
      pack_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      slot_idx_q <= slot_idx_d;
      pack_q     <= pack_d;
      overflow_q <= overflow_d;
    end
  end

  lane_beat_fifo #(
    .beat_t (beat_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (push_beat_c),
    .pop   (pop_c),
    .head  (head_c),
    .count (o_count),
    .full  (fifo_full_c),
    .empty (fifo_empty_c)
  );

  assign o_data_v   = ~fifo_empty_c;
  assign o_data     = head_c.data;
  assign o_keep     = head_c.keep;
  assign o_last     = head_c.last;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_lane_result_packer.sv
// Self-checking bench for lane_result_packer (PACK=2, DEPTH=8).
// Expected beats are queued as stimulus is driven and compared when the
// DUT hands a beat over on the valid/ready interface.
module tb_lane_result_packer;

  localparam int unsigned DW = 64;
  localparam int unsigned PK = 2;
  localparam int unsigned DP = 8;
  localparam int unsigned OW = DW * PK;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [PK-1:0] keep;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_data_v = 1'b0;
  logic          i_flush = 1'b0;
  logic [OW-1:0] o_data;
  logic          o_data_v;
  logic          o_data_rdy = 1'b0;
  logic [PK-1:0] o_keep;
  logic          o_last;
  logic [3:0]    o_count;
  logic          o_overflow;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   beats_seen = 0;
  exp_t exp_q[$];

  lane_result_packer #(.DATA_W(DW), .PACK(PK), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_data_v   (i_data_v),
    .i_flush    (i_flush),
    .o_data     (o_data),
    .o_data_v   (o_data_v),
    .o_data_rdy (o_data_rdy),
    .o_keep     (o_keep),
    .o_last     (o_last),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
`ifdef LANE_RESULT_PACKER_RELU_EN
    for (int b = 0; b < DW/8; b++) if (v[b*8+7]) r[b*8 +: 8] = 8'h00;
`endif
    return r;
  endfunction

  function automatic exp_t mk(input logic [OW-1:0] d, input logic [PK-1:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    return e;
  endfunction

  // Scoreboard: every accepted beat must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && o_data_v && o_data_rdy) begin
      beats_seen++;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got data=%h keep=%b last=%b, required no beat", o_data, o_keep, o_last);
      end else begin
        if ({o_data, o_keep, o_last} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL beat_content: got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                   o_data, o_keep, o_last, exp_q[0].data, exp_q[0].keep, exp_q[0].last);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [DW-1:0] d, input logic v, input logic f);
    i_data   = d;
    i_data_v = v;
    i_flush  = f;
    @(posedge clk);
    #1;
    i_data_v = 1'b0;
    i_flush  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    #12;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input string name);
    o_data_rdy = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({o_data_v, o_keep, o_last, o_overflow} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got v=%b keep=%b last=%b ovf=%b, required 0", o_data_v, o_keep, o_last, o_overflow);
    end
    n_assert++;
    if (o_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", o_data); end
    n_assert++;
    if (o_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", o_count); end
  endtask

  task automatic test_pack();
    logic [DW-1:0] a, b, c, d;
    a = 64'h0123456789ABCDEF; b = 64'h1122334455667788;
    c = 64'h7F00FF8001020304; d = 64'hDEADBEEF00C0FFEE;
    o_data_rdy = 1'b1;
    drive(a, 1'b1, 1'b0);
    n_assert++;
    if (o_data_v !== 1'b0) begin n_fail++; $display("FAIL pack_half_valid: got %b, required 0", o_data_v); end
    exp_q.push_back(mk({relu(b), relu(a)}, 2'b11, 1'b0));
    drive(b, 1'b1, 1'b0);
    #3;
    n_assert++;
    if (o_data_v !== 1'b1) begin n_fail++; $display("FAIL pack_latency: got valid=%b, required 1", o_data_v); end
    drive(c, 1'b1, 1'b0);
    exp_q.push_back(mk({relu(d), relu(c)}, 2'b11, 1'b0));
    drive(d, 1'b1, 1'b0);
    drain("pack");
  endtask

  task automatic test_flush();
    int seen;
    logic [DW-1:0] a;
    a = 64'h0102030405060708;
    drive(a, 1'b1, 1'b0);
    exp_q.push_back(mk({64'h0, relu(a)}, 2'b01, 1'b1));
    drive('0, 1'b0, 1'b1);
    drain("flush");
    seen = beats_seen;
    drive('0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (beats_seen != seen || o_count !== 4'd0) begin
      n_fail++; $display("FAIL flush_noop: got beats=%0d count=%0d, required beats=%0d count=0", beats_seen, o_count, seen);
    end
    // Data arriving with flush completes the beat, only one beat results.
    drive(64'hA0A1A2A3A4A5A6A7, 1'b1, 1'b0);
    exp_q.push_back(mk({relu(64'h0B1B2B3B4B5B6B7B), relu(64'hA0A1A2A3A4A5A6A7)}, 2'b11, 1'b1));
    seen = beats_seen;
    drive(64'h0B1B2B3B4B5B6B7B, 1'b1, 1'b1);
    drain("flush_data");
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if (beats_seen != seen + 1) begin n_fail++; $display("FAIL flush_data_count: got %0d beats, required 1", beats_seen - seen); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] lo, hi;
    o_data_rdy = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      lo = {32'h1000_0000 + 32'(n), 32'h0000_0001};
      hi = {32'h2000_0000 + 32'(n), 32'h0000_0002};
      if (n <= 8) exp_q.push_back(mk({relu(hi), relu(lo)}, 2'b11, 1'b0));
      drive(lo, 1'b1, 1'b0);
      drive(hi, 1'b1, 1'b0);
    end
    n_assert++;
    if (o_count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d, required 8", o_count); end
    n_assert++;
    if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", o_overflow); end
    drain("ovf");
    n_assert++;
    if (o_overflow !== 1'b1 || o_count !== 4'd0) begin
      n_fail++; $display("FAIL ovf_sticky: got ovf=%b count=%0d, required ovf=1 count=0", o_overflow, o_count);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    drive(64'h5555AAAA5555AAAA, 1'b1, 1'b0);
    do_reset();
    n_assert++;
    if (o_overflow !== 1'b0 || o_count !== 4'd0) begin
      n_fail++; $display("FAIL midreset_state: got ovf=%b count=%0d, required 0 0", o_overflow, o_count);
    end
    seen = beats_seen;
    o_data_rdy = 1'b1;
    drive('0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (beats_seen != seen) begin n_fail++; $display("FAIL midreset_slot: got %0d beats, required 0", beats_seen - seen); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] lo, hi;
    o_data_rdy = 1'b0;
    for (int n = 0; n < 8; n++) begin
      lo = {32'(n), 32'hCAFE_0000};
      hi = {32'(n), 32'hBEEF_0000};
      exp_q.push_back(mk({relu(hi), relu(lo)}, 2'b11, 1'b0));
      drive(lo, 1'b1, 1'b0);
      drive(hi, 1'b1, 1'b0);
    end
    n_assert++;
    if (o_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d, required 8", o_count); end
    lo = 64'h0F0E0D0C0B0A0908;
    hi = 64'h7766554433221100;
    exp_q.push_back(mk({relu(hi), relu(lo)}, 2'b11, 1'b0));
    drive(lo, 1'b1, 1'b0);
    o_data_rdy = 1'b1;
    drive(hi, 1'b1, 1'b0);
    o_data_rdy = 1'b0;
    n_assert++;
    if (o_count !== 4'd8 || o_overflow !== 1'b0) begin
      n_fail++; $display("FAIL pushpop_full: got count=%0d ovf=%b, required count=8 ovf=0", o_count, o_overflow);
    end
    drain("pushpop");
  endtask

  task automatic test_random();
    logic [DW-1:0] v, prev;
    int slot;
    slot = 0;
    prev = '0;
    for (int i = 0; i < 41; i++) begin
      v = {$urandom, $urandom};
      o_data_rdy = ($urandom_range(0, 3) != 0) || (o_count >= 4'd4);
      if (slot == 0) begin
        prev = v; slot = 1;
      end else begin
        exp_q.push_back(mk({relu(v), relu(prev)}, 2'b11, 1'b0)); slot = 0;
      end
      drive(v, 1'b1, 1'b0);
    end
    exp_q.push_back(mk({64'h0, relu(prev)}, 2'b01, 1'b1));
    drive('0, 1'b0, 1'b1);
    drain("random");
    n_assert++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL random_ovf: got %b, required 0", o_overflow); end
  endtask

  task automatic test_relu();
    logic [DW-1:0] v, e;
    v = 64'h807FFF01009010C0;
`ifdef LANE_RESULT_PACKER_RELU_EN
    e = 64'h007F000100001000;
`else
    e = v;
`endif
    exp_q.push_back(mk({64'h0, e}, 2'b01, 1'b1));
    drive(v, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b1);
    drain("relu");
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush();
    test_overflow();
    test_reset_midop();
    test_back_to_back();
    test_random();
    test_relu();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
